alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr  input  32  MIPS word: opcode=[31:26], funct=[5:0], imm=[15:0].
REQ-006 rs_val, rt_val  input  32 each  operand values accompanying instr.
REQ-007 instr_ready  output  1  block can accept an instruction.
REQ-008 alu_opcode, alu_func  output  6 each  registered drive to the ALU opcode and func_field inputs.
REQ-009 alu_a, alu_b  output  32 each  registered drive to the ALU A and B inputs.
REQ-010 alu_result  input  32, alu_zero  input  1  combinational ALU outputs.
REQ-011 out_valid  output  1  response available; out_ready  input  1  consumer accepts.
REQ-012 out_result  output  32, out_zero  output  1, out_branch_taken  output  1, out_illegal  output  1  response payload.
REQ-013 op_count  output  CNT_W  count of completed responses.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, RESP; instr_ready SHALL be 1 only in IDLE.
REQ-015 Accept = instr_valid & instr_ready at a rising edge; the instruction is decoded and registered on that edge.
REQ-016 Legal set: opcode 0x00 with funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT; opcode 0x23 LW; 0x2B SW; 0x04 BEQ.
REQ-017 R-type accept SHALL load alu_opcode=0x00, alu_func=funct, alu_a=rs_val, alu_b=rt_val; next state ISSUE.
REQ-018 LW/SW accept SHALL load alu_opcode=instr opcode, alu_func=0x00, alu_a=rs_val, alu_b=sign-extended imm to 32 bits; next state ISSUE.
REQ-019 BEQ accept SHALL load alu_opcode=0x04, alu_func=0x00, alu_a=rs_val, alu_b=rt_val; next state ISSUE.
REQ-020 Illegal accept SHALL leave alu_* unchanged, load out_result=0, out_zero=0, out_branch_taken=0, out_illegal=1, and go directly to RESP.
REQ-021 In ISSUE (exactly one cycle) the block SHALL capture out_result=alu_result, out_zero=alu_zero, out_branch_taken=alu_zero if BEQ else 0, out_illegal=0, and go to RESP.
REQ-022 Latency: legal op accepted at edge N gives out_valid=1 after edge N+1; illegal op gives out_valid=1 after edge N.
REQ-023 out_valid SHALL be 1 exactly in RESP; payload SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 In RESP with out_ready=1 the block SHALL return to IDLE and increment op_count by 1 (illegal responses included).
REQ-025 op_count SHALL wrap from all-ones to 0.
REQ-026 alu_* outputs SHALL hold their last value outside accept edges.
REQ-027 instr_valid while not in IDLE SHALL be ignored; no new instruction is latched before RESP completes.
REQ-028 out_ready while not in RESP SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and all outputs to 0 (alu_*, out_*, op_count), independent of clk.
REQ-030 Reset mid-ISSUE or mid-RESP SHALL discard the pending operation without incrementing op_count; instr_ready=1 on the first edge after release.

Verification
REQ-031 ADD: rs=0x2222, rt=0x1111, instr opcode 0x00 funct 0x20 -> alu_a=0x2222, alu_b=0x1111, out_result=0x3333, out_zero=0, out_valid two edges after accept.
REQ-032 LW: opcode 0x23, rs=0x2222, imm=0xFFFC -> alu_b=0xFFFFFFFC, out_result=0x221E; AND funct 0x24 with 0x2222/0x1111 -> out_result=0, out_zero=1.
REQ-033 BEQ: rs=rt=0x5555 -> out_zero=1, out_branch_taken=1; SLT rs=0x1111, rt=0x2222 -> out_result=1, out_branch_taken=0.
REQ-034 Illegal funct 0x3F with opcode 0x00 -> out_valid one edge after accept, out_illegal=1, out_result=0, alu_* unchanged, op_count increments on handshake.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles with instr_valid=1 and new instr -> payload stable, instr_ready=0, second instr accepted only after RESP handshake.
REQ-036 Assert rst_n=0 during ISSUE -> all outputs 0 asynchronously, op_count unchanged from 0, next accept works normally; CNT_W=4 run of 16 ops -> op_count wraps to 0.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction offer, ALU drive/return and response signals of alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [31:0]      rs_val;
    logic [31:0]      rt_val;
    logic [5:0]       alu_opcode;
    logic [5:0]       alu_func;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_zero;
    logic             out_branch_taken;
    logic             out_illegal;
    logic [CNT_W-1:0] op_count;
    modport master (
        output instr_valid, instr, rs_val, rt_val, alu_result, alu_zero, out_ready,
        input  instr_ready, alu_opcode, alu_func, alu_a, alu_b, out_valid, out_result,
               out_zero, out_branch_taken, out_illegal, op_count
    );
    modport slave (
        input  instr_valid, instr, rs_val, rt_val, alu_result, alu_zero, out_ready,
        output instr_ready, alu_opcode, alu_func, alu_a, alu_b, out_valid, out_result,
               out_zero, out_branch_taken, out_illegal, op_count
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one MIPS ALU/memory/branch instruction at a time,
// drives an external ALU for one cycle and holds the response until taken.
module alu_issue_ctrl #(
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t           r_state;
    logic [5:0]       r_alu_opcode;
    logic [5:0]       r_alu_func;
    logic [31:0]      r_alu_a;
    logic [31:0]      r_alu_b;
    logic [31:0]      r_out_result;
    logic             r_out_zero;
    logic             r_out_branch_taken;
    logic             r_out_illegal;
    logic             r_is_beq;
    logic [CNT_W-1:0] r_op_count;
    logic [5:0]       w_op;
    logic [5:0]       w_fn;
    logic [31:0]      w_imm_sext;
    logic             w_rtype;
    logic             w_mem;
    logic             w_beq;
    logic             w_legal;
    logic             w_unused;
    assign w_op       = bus.instr[31:26];
    assign w_fn       = bus.instr[5:0];
    assign w_imm_sext = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign w_rtype    = (w_op == 6'h00) && (w_fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
    assign w_mem      = (w_op == 6'h23) || (w_op == 6'h2B);
    assign w_beq      = (w_op == 6'h04);
    assign w_legal    = w_rtype || w_mem || w_beq;
    assign w_unused   = ^bus.instr[25:16];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= IDLE;
            r_alu_opcode       <= '0;
            r_alu_func         <= '0;
            r_alu_a            <= '0;
            r_alu_b            <= '0;
            r_out_result       <= '0;
            r_out_zero         <= 1'b0;
            r_out_branch_taken <= 1'b0;
            r_out_illegal      <= 1'b0;
            r_is_beq           <= 1'b0;
            r_op_count         <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.instr_valid) begin
                    if (w_legal) begin
                        // Legal opcodes already equal the ALU opcode they need (0x00/0x23/0x2B/0x04)
                        r_alu_opcode <= w_op;
                        r_alu_func   <= w_rtype ? w_fn : 6'h00;
                        r_alu_a      <= bus.rs_val;
                        r_alu_b      <= w_mem ? w_imm_sext : bus.rt_val;
                        r_is_beq     <= w_beq;
                        r_state      <= ISSUE;
                    end else begin
                        r_out_result       <= '0;
                        r_out_zero         <= 1'b0;
                        r_out_branch_taken <= 1'b0;
                        r_out_illegal      <= 1'b1;
                        r_state            <= RESP;
                    end
                end
                ISSUE: begin
                    r_out_result       <= bus.alu_result;
                    r_out_zero         <= bus.alu_zero;
                    r_out_branch_taken <= r_is_beq & bus.alu_zero;
                    r_out_illegal      <= 1'b0;
                    r_state            <= RESP;
                end
                RESP: if (bus.out_ready) begin
                    r_op_count <= r_op_count + CNT_W'(1);
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.instr_ready      = (r_state == IDLE);
    assign bus.out_valid        = (r_state == RESP);
    assign bus.alu_opcode       = r_alu_opcode;
    assign bus.alu_func         = r_alu_func;
    assign bus.alu_a            = r_alu_a;
    assign bus.alu_b            = r_alu_b;
    assign bus.out_result       = r_out_result;
    assign bus.out_zero         = r_out_zero;
    assign bus.out_branch_taken = r_out_branch_taken;
    assign bus.out_illegal      = r_out_illegal;
    assign bus.op_count         = r_op_count;
endmodule
